// File: rtl/da_dct_pkg.sv
// Shared definitions for the bit-serial DA ROM-row sequencers: state encoding,
// default widths and the ROM address/negate decode.
package da_dct_pkg;

    localparam int DA_DW = 16;
    localparam int DA_RW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } da_state_e;

    // Only the rows with b0=0 are stored; b0=1 reads the complemented row and negates it.
    function automatic logic [3:0] da_addr(input logic b0, input logic b1,
                                           input logic b2, input logic b3);
        logic [2:0] a;
        a = {b1, b2, b3};
        if (b0) begin
            return {~a, 1'b1};
        end else begin
            return {a, 1'b0};
        end
    endfunction

endpackage

// File: rtl/da_shift_acc.sv
// Shift-accumulator: adds or subtracts a sign-extended ROM word shifted left by
// the current bit-slice index.
module da_shift_acc
    import da_dct_pkg::*;
#(
    parameter int RW = DA_RW,
    parameter int ZW = 2 * DA_RW,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          sub,
    input  logic [SW-1:0] shamt,
    input  logic [RW-1:0] din,
    output logic [ZW-1:0] acc
);

    logic [ZW-1:0] ext_s;
    logic [ZW-1:0] term_s;
    logic [ZW-1:0] acc_r;

    // Sign-extend the ROM word to full width and weight it by the slice position.
    always_comb begin
        ext_s  = {{(ZW-RW){din[RW-1]}}, din};
        term_s = ext_s << shamt;
    end

    // Accumulator register; clear wins over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ZW{1'b0}};
        end else if (clr) begin
            acc_r <= {ZW{1'b0}};
        end else if (en) begin
            if (sub) begin
                acc_r <= acc_r - term_s;
            end else begin
                acc_r <= acc_r + term_s;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/da_rom_seq_ctrl.sv
// Bit-serial DA sequencer for one DCT coefficient: walks four samples LSB first,
// addresses the external coefficient ROM and shift-accumulates its words.
module da_rom_seq_ctrl
    import da_dct_pkg::*;
#(
    parameter int DW = DA_DW,
    parameter int RW = DA_RW,
    parameter int ZW = DW + RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] x1,
    input  logic [DW-1:0] x2,
    input  logic [DW-1:0] x3,
    output logic [2:0]    rom_addr,
    output logic          rom_cs,
    input  logic [RW-1:0] rom_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [ZW-1:0] z,
    output logic          busy
);

    localparam int JW = $clog2(DW);
    localparam logic [1:0]    S_IDLE = IDLE;
    localparam logic [1:0]    S_RUN  = RUN;
    localparam logic [1:0]    S_DONE = DONE;
    localparam logic [JW-1:0] J_LAST = JW'(DW - 1);

    logic [1:0]    state_r;
    logic [JW-1:0] j_r;
    logic [DW-1:0] x0_r, x1_r, x2_r, x3_r;
    logic [3:0]    da_s;
    logic          run_s;
    logic          accept_s;
    logic          last_s;
    logic [ZW-1:0] acc_s;

    assign in_ready = (state_r == S_IDLE) && !rst;

    // Slice decode and ROM port drive; the ROM is only touched in RUN.
    always_comb begin
        run_s    = (state_r == S_RUN);
        accept_s = in_valid && in_ready;
        last_s   = run_s && (j_r == J_LAST);
        da_s     = da_addr(x0_r[0], x1_r[0], x2_r[0], x3_r[0]);
        if (run_s) begin
            rom_addr = da_s[3:1];
            rom_cs   = 1'b1;
        end else begin
            rom_addr = 3'b000;
            rom_cs   = 1'b0;
        end
    end

    // Sequencer FSM, slice counter and sample shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            j_r     <= {JW{1'b0}};
            x0_r    <= {DW{1'b0}};
            x1_r    <= {DW{1'b0}};
            x2_r    <= {DW{1'b0}};
            x3_r    <= {DW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r <= S_RUN;
                        j_r     <= {JW{1'b0}};
                        x0_r    <= x0;
                        x1_r    <= x1;
                        x2_r    <= x2;
                        x3_r    <= x3;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    x0_r <= {1'b0, x0_r[DW-1:1]};
                    x1_r <= {1'b0, x1_r[DW-1:1]};
                    x2_r <= {1'b0, x2_r[DW-1:1]};
                    x3_r <= {1'b0, x3_r[DW-1:1]};
                    if (last_s) begin
                        state_r <= S_DONE;
                        j_r     <= {JW{1'b0}};
                    end else begin
                        j_r <= j_r + {{(JW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    j_r     <= {JW{1'b0}};
                end
            endcase
        end
    end

    // The sign slice carries negative weight, so it flips the add/sub sense.
    da_shift_acc #(
        .RW (RW),
        .ZW (ZW),
        .SW (JW)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_s),
        .en    (run_s),
        .sub   (da_s[0] ^ last_s),
        .shamt (j_r),
        .din   (rom_data),
        .acc   (acc_s)
    );

    assign z         = acc_s;
    assign out_valid = (state_r == S_DONE);
    assign busy      = (state_r != S_IDLE);

endmodule

// File: tb/tb_da_rom_seq_ctrl.sv
// Self-checking bench for da_rom_seq_ctrl with a behavioural coefficient model.
module tb_da_rom_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x0, x1, x2, x3;
    logic [2:0]  rom_addr;
    logic        rom_cs;
    logic [15:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] cap_addr [16];
    logic       cap_cs   [16];
    int         lat;

    always #5 clk = ~clk;

    da_rom_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .rom_addr  (rom_addr),
        .rom_cs    (rom_cs),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    // ROM row: w1*b1 + w2*b2 + w3*b3 with address {b1,b2,b3}
    function automatic int rom_val(input logic [2:0] a);
        case (a)
            3'd0: return 0;
            3'd1: return 15137;
            3'd2: return 6269;
            3'd3: return 21406;
            3'd4: return 3196;
            3'd5: return 18333;
            3'd6: return 9465;
            3'd7: return 24602;
            default: return 0;
        endcase
    endfunction

    assign rom_data = 16'(rom_val(rom_addr));

    function automatic logic [2:0] model_addr(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c, input logic [15:0] d,
                                              input int j);
        logic [2:0] k;
        k = {b[j], c[j], d[j]};
        return a[j] ? ~k : k;
    endfunction

    function automatic logic [31:0] model_z(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [15:0] d);
        longint s, p, w, one;
        logic [2:0] k, kn;
        s = 0;
        one = 1;
        for (int j = 0; j < 16; j++) begin
            k  = {b[j], c[j], d[j]};
            kn = ~k;
            p  = a[j] ? -longint'(rom_val(kn)) : longint'(rom_val(k));
            w  = (j == 15) ? -(one << 15) : (one << j);
            s  = s + p * w;
        end
        return s[31:0];
    endfunction

    // Present one set from IDLE and run until out_valid, capturing per-slice ROM drive.
    task automatic send_set(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        x0 = a; x1 = b; x2 = c; x3 = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (lat <= 16) begin
                cap_addr[lat-1] = rom_addr;
                cap_cs[lat-1]   = rom_cs;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x0 = 16'd0; x1 = 16'd0; x2 = 16'd0; x3 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({in_ready, out_valid, busy, rom_cs, rom_addr, z} !== 38'd0) begin
            $display("FAIL reset_outputs: got ir=%b ov=%b busy=%b cs=%b addr=%b z=%h, want all zero",
                     in_ready, out_valid, busy, rom_cs, rom_addr, z);
        end else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_zero();
        int bad;
        send_set(16'd0, 16'd0, 16'd0, 16'd0);
        bad = 0;
        for (int j = 0; j < 16; j++) if (cap_addr[j] !== 3'b000 || cap_cs[j] !== 1'b1) bad++;
        n_total++;
        if (bad != 0) $display("FAIL zero_addr: %0d slices had addr!=000 or cs!=1, want 0", bad);
        else n_pass++;
        n_total++;
        if (lat != 17) $display("FAIL zero_latency: out_valid at T+%0d want T+17", lat);
        else n_pass++;
        n_total++;
        if (z !== 32'd0) $display("FAIL zero_z: got %h want 0", z);
        else n_pass++;
        drain();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || rom_cs !== 1'b0)
            $display("FAIL zero_drain: ov=%b ir=%b cs=%b want 0 1 0", out_valid, in_ready, rom_cs);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] tx [5][4];
        logic [31:0] tz [5];
        tx[0] = '{16'd0, 16'd0, 16'd1, 16'd0};      tz[0] = 32'd6269;
        tx[1] = '{16'd0, 16'd0, 16'd2, 16'd0};      tz[1] = 32'd12538;
        tx[2] = '{16'd0, 16'd0, 16'd1, 16'd1};      tz[2] = 32'd21406;
        tx[3] = '{16'd0, 16'd0, 16'hFFFF, 16'd0};   tz[3] = -32'sd6269;
        tx[4] = '{16'd1, 16'd1, 16'd0, 16'd1};      tz[4] = -32'sd6269;
        for (int i = 0; i < 5; i++) begin
            send_set(tx[i][0], tx[i][1], tx[i][2], tx[i][3]);
            n_total++;
            if (z !== tz[i]) $display("FAIL directed_z[%0d]: got %0d want %0d", i, $signed(z), $signed(tz[i]));
            else n_pass++;
            if (i == 0 || i == 4) begin
                n_total++;
                if (cap_addr[0] !== 3'b010) $display("FAIL directed_addr0[%0d]: got %b want 010", i, cap_addr[0]);
                else n_pass++;
            end
            drain();
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, c, d;
        int bad;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom()); b = 16'($urandom()); c = 16'($urandom()); d = 16'($urandom());
            send_set(a, b, c, d);
            bad = 0;
            for (int j = 0; j < 16; j++) if (cap_addr[j] !== model_addr(a, b, c, d, j)) bad++;
            n_total++;
            if (bad != 0 || lat != 17) $display("FAIL random_addr[%0d]: %0d bad slices, lat %0d, want 0 and 17", i, bad, lat);
            else n_pass++;
            n_total++;
            if (z !== model_z(a, b, c, d)) $display("FAIL random_z[%0d]: got %h want %h", i, z, model_z(a, b, c, d));
            else n_pass++;
            drain();
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] held;
        int bad;
        send_set(16'd3, 16'd0, 16'd5, 16'd7);
        held = model_z(16'd3, 16'd0, 16'd5, 16'd7);
        x0 = 16'd0; x1 = 16'd9; x2 = 16'd1; x3 = 16'd0;
        in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || z !== held || in_ready !== 1'b0 || busy !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        n_total++;
        if (bad != 0) $display("FAIL bp_hold: %0d cycles lost z/out_valid or raised in_ready, want 0", bad);
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== held)
            $display("FAIL bp_release: ov=%b ir=%b z=%h want 0 1 %h", out_valid, in_ready, z, held);
        else n_pass++;
        send_set(16'd0, 16'd9, 16'd1, 16'd0);
        n_total++;
        if (z !== model_z(16'd0, 16'd9, 16'd1, 16'd0) || lat != 17)
            $display("FAIL bp_next_set: z=%h lat=%0d want %h 17", z, lat, model_z(16'd0, 16'd9, 16'd1, 16'd0));
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_midrun();
        x0 = 16'hFFFF; x1 = 16'h1234; x2 = 16'hAAAA; x3 = 16'h5555;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_total++;
        if (rom_cs !== 1'b1 || busy !== 1'b1) $display("FAIL midrun_running: cs=%b busy=%b want 1 1", rom_cs, busy);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({in_ready, out_valid, busy, rom_cs, rom_addr, z} !== 38'd0)
            $display("FAIL midrun_reset: ir=%b ov=%b busy=%b cs=%b addr=%b z=%h want all zero",
                     in_ready, out_valid, busy, rom_cs, rom_addr, z);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        send_set(16'd1, 16'd0, 16'd0, 16'd0);
        n_total++;
        if (z !== model_z(16'd1, 16'd0, 16'd0, 16'd0))
            $display("FAIL midrun_after: z=%h want %h", z, model_z(16'd1, 16'd0, 16'd0, 16'd0));
        else n_pass++;
        drain();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
